// File: rtl/am2950_port.sv
// Am2950-style bidirectional port: two independent handshake registers (R: A->B, S: B->A)
// with full/overrun flags and three-state bus outputs.

module am2950_channel #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned AUTOCLR = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_ce_n,
  input  logic             i_oe_n,
  input  logic             i_clr_n,
  output logic [WIDTH-1:0] o_q,
  output logic             o_full,
  output logic             o_ovr
);

  localparam bit AutoClrEn = (AUTOCLR != 0);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state = ST_EMPTY;
  state_t           w_next;
  logic [WIDTH-1:0] r_data  = '0;
  logic             r_ovr   = 1'b0;
  logic             w_load;
  logic             w_clear;
  logic             w_setOvr;

  // A bus read counts as an acknowledge only in auto-clear builds.
  assign w_load  = ~i_ce_n;
  assign w_clear = ~i_clr_n | (AutoClrEn & ~i_oe_n);

  always_comb begin
    w_next   = r_state;
    w_setOvr = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_load) w_next = ST_FULL;
      end
      ST_FULL: begin
        if (w_load) begin
          w_next   = ST_FULL;
          w_setOvr = ~w_clear;
        end else if (w_clear) begin
          w_next = ST_EMPTY;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load)   r_data <= i_d;
      if (w_setOvr) r_ovr  <= 1'b1;
    end
  end

  assign o_q    = r_data;
  assign o_full = (r_state == ST_FULL);
  assign o_ovr  = r_ovr;

endmodule

module am2950_port #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned AUTOCLR = 0
) (
  input  logic             cp,
  input  logic             clr,
  input  logic [WIDTH-1:0] a_d,
  input  logic             ce_r_,
  input  logic             oe_r_,
  input  logic             clrr_,
  input  logic [WIDTH-1:0] b_d,
  input  logic             ce_s_,
  input  logic             oe_s_,
  input  logic             clrs_,
  output logic [WIDTH-1:0] r_q,
  output logic [WIDTH-1:0] s_q,
  output wire  [WIDTH-1:0] b_y,
  output wire  [WIDTH-1:0] a_y,
  output logic             fr,
  output logic             fs,
  output logic             ovr_r,
  output logic             ovr_s
);

  logic [WIDTH-1:0] w_rq;
  logic [WIDTH-1:0] w_sq;

  am2950_channel #(.WIDTH(WIDTH), .AUTOCLR(AUTOCLR)) u_chanR (
    .i_clk  (cp),
    .i_rst  (clr),
    .i_d    (a_d),
    .i_ce_n (ce_r_),
    .i_oe_n (oe_r_),
    .i_clr_n(clrr_),
    .o_q    (w_rq),
    .o_full (fr),
    .o_ovr  (ovr_r)
  );

  am2950_channel #(.WIDTH(WIDTH), .AUTOCLR(AUTOCLR)) u_chanS (
    .i_clk  (cp),
    .i_rst  (clr),
    .i_d    (b_d),
    .i_ce_n (ce_s_),
    .i_oe_n (oe_s_),
    .i_clr_n(clrs_),
    .o_q    (w_sq),
    .o_full (fs),
    .o_ovr  (ovr_s)
  );

  // Bus drivers are purely combinational on the enable and the stored value.
  assign r_q = w_rq;
  assign s_q = w_sq;
  assign b_y = oe_r_ ? {WIDTH{1'bz}} : w_rq;
  assign a_y = oe_s_ ? {WIDTH{1'bz}} : w_sq;

endmodule

// File: doc/am2950_port.md
AM2950_PORT -- requirements
Module: am2950_port

Interface
REQ-001 Parameter WIDTH, default 8, sets the data width of both port registers.
REQ-002 Parameter AUTOCLR, default 0; when 1, a bus read of a register clears that register's flag.
REQ-003 cp  input  1  clock; all state changes on its rising edge; this is the only clock.
REQ-004 clr  input  1  reset; synchronous and active-high.
REQ-005 a_d  input  WIDTH  A-side data into the R register.
REQ-006 ce_r_  input  1  R load enable, active low.
REQ-007 oe_r_  input  1  b_y output enable, active low.
REQ-008 clrr_  input  1  R flag clear (B-side acknowledge), active low.
REQ-009 b_d  input  WIDTH  B-side data into the S register.
REQ-010 ce_s_  input  1  S load enable, active low.
REQ-011 oe_s_  input  1  a_y output enable, active low.
REQ-012 clrs_  input  1  S flag clear (A-side acknowledge), active low.
REQ-013 r_q  output  WIDTH  R register, standard (always-driven) output.
REQ-014 s_q  output  WIDTH  S register, standard output.
REQ-015 b_y  output  WIDTH  three-state R output: r_q when oe_r_=0, else all Z.
REQ-016 a_y  output  WIDTH  three-state S output: s_q when oe_s_=0, else all Z.
REQ-017 fr, fs  output  1 each  R/S full flags (unread data present).
REQ-018 ovr_r, ovr_s  output  1 each  sticky overrun flags.

Function
REQ-019 The R and S channels are identical and fully independent; the R-channel rules below apply equally to S (b_d, ce_s_, oe_s_, clrs_, fs, ovr_s).
REQ-020 Load: ce_r_=0 at an edge -> r_q <= a_d; 1-cycle latency; r_q holds otherwise.
REQ-021 Flag state machine, two states: EMPTY (fr=0) and FULL (fr=1).
REQ-022 EMPTY -> FULL on load; FULL -> EMPTY on clear with no load; otherwise state holds.
REQ-023 Clear source: clrr_=0, or, when AUTOCLR=1, oe_r_=0 sampled at the edge.
REQ-024 Simultaneous load and clear -> FULL: the new data wins and no overrun is flagged.
REQ-025 Load in FULL without a simultaneous clear -> data is overwritten, state stays FULL, ovr_r <= 1.
REQ-026 ovr_r is sticky: it is cleared only by clr; clrr_ does not affect it.
REQ-027 Clear while EMPTY -> no effect.
REQ-028 b_y and a_y are purely combinational on oe_x_ and the register value; the output enables never alter register contents (except via AUTOCLR in REQ-023).
REQ-029 No arithmetic; data passes bit-exact, WIDTH bits, no width conversion.

Reset
REQ-030 clr=1 at an edge -> r_q, s_q = 0; fr, fs = 0; ovr_r, ovr_s = 0; this overrides any simultaneous load or clear.
REQ-031 During clr, b_y and a_y still follow the output enables (0 when enabled, Z otherwise).
REQ-032 Power-up (pre-reset) value of all registers and flags is 0.
REQ-033 Reset asserted mid-transfer (FULL) discards the data; the next load after clr deasserts behaves as from EMPTY.

Verification
REQ-034 WIDTH=8, clr 1 cycle, then a_d=0x5A with ce_r_=0 for 1 cycle -> next cycle r_q=0x5A, fr=1, ovr_r=0; oe_r_=0 -> b_y=0x5A; oe_r_=1 -> b_y=Z.
REQ-035 FULL R, load a_d=0x33 with clrr_=1 -> r_q=0x33, fr=1, ovr_r=1; then clrr_=0 -> fr=0, ovr_r stays 1.
REQ-036 FULL R, ce_r_=0 with a_d=0xC3 and clrr_=0 in the same cycle -> r_q=0xC3, fr=1, ovr_r=0.
REQ-037 AUTOCLR=1: load S with b_d=0x81, then oe_s_=0 for 1 cycle -> a_y=0x81 during that cycle, fs=0 after the edge; R channel unaffected.
REQ-038 Both channels FULL with ovr set, clr=1 together with ce_r_=0 -> all registers and flags 0 after the edge.
REQ-039 Random concurrent R/S traffic against a reference flag model -> fr, fs, ovr_r and ovr_s match every cycle.
